// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and widths for the memory access controller.
package mem_access_ctrl_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;
endpackage

// File: rtl/latency_counter.sv
// Down-counter that times the memory strobe window; zero flag marks the last cycle.
module latency_counter
    import mem_access_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding request/response front end for a data memory with fixed strobe latency.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int                MEM_LATENCY = 2,
    parameter logic [DATA_W-1:0] ADDR_LIMIT  = 16'd1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemtoReg,
    output logic [DATA_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] outData
);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

    state_e            state_q;
    logic              req_ready_q, resp_valid_q, resp_err_q;
    logic              mem_read_q, mem_write_q;
    logic              wr_q, err_q;
    logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
    logic              hs, legal, cnt_zero;

    assign hs    = (state_q == IDLE) && req_valid && req_ready_q;
    assign legal = (req_addr <= ADDR_LIMIT);

    // Counter holds the number of strobe cycles still to go after the current one.
    latency_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (hs && legal),
        .dec_i  ((state_q == ACCESS) && !cnt_zero),
        .val_i  (LOAD_VAL),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        req_ready_q <= 1'b0;
                        wr_q        <= req_write;
                        rdata_q     <= '0;
                        resp_err_q  <= 1'b0;
                        err_q       <= !legal;
                        if (legal) begin
                            state_q     <= ACCESS;
                            addr_q      <= req_addr;
                            wdata_q     <= req_wdata;
                            mem_read_q  <= !req_write;
                            mem_write_q <= req_write;
                        end else begin
                            state_q <= RESP;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (!wr_q) rdata_q <= outData;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // One settling cycle in RESP before the response is presented.
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                    end else if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;
    assign MemRead    = mem_read_q;
    assign MemtoReg   = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign Address    = addr_q;
    assign WriteData  = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed checks of mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;
    localparam int          L     = 2;
    localparam logic [15:0] LIMIT = 16'd1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, MemRead, MemWrite, MemtoReg;
    logic [15:0] resp_rdata, Address, WriteData, outData;

    logic        req_valid1 = 1'b0, resp_ready1 = 1'b0;
    logic [15:0] req_addr1 = '0;
    logic        req_ready1, resp_valid1, resp_err1, MemRead1, MemWrite1, MemtoReg1;
    logic [15:0] resp_rdata1, Address1, WriteData1, outData1;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LATENCY(L), .ADDR_LIMIT(LIMIT)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .Address(Address), .WriteData(WriteData), .outData(outData));

    mem_access_ctrl #(.MEM_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_write(1'b0),
        .req_addr(req_addr1), .req_wdata(16'h0), .req_ready(req_ready1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1),
        .resp_err(resp_err1), .MemRead(MemRead1), .MemWrite(MemWrite1), .MemtoReg(MemtoReg1),
        .Address(Address1), .WriteData(WriteData1), .outData(outData1));

    // Data memory seen by the DUT, and an independent reference copy for the model.
    logic [15:0] dmem    [0:1023];
    logic [15:0] ref_mem [0:1023];
    assign outData  = dmem[Address[9:0]];
    assign outData1 = {6'd0, Address1[9:0]} ^ 16'h3C3C;
    always @(posedge clk) if (MemWrite) dmem[Address[9:0]] <= WriteData;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // Transaction-level model: a handshake at edge N opens a strobe window of L edges
    // starting at N (legal only) and the response appears from edge N+L+1 (N+1 on error).
    int          ecnt = 0, hs_e = 0, resp_at = 0;
    bit          m_busy = 0, m_rdy = 0, m_legal = 0, m_write = 0, m_err = 0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_data = '0;

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        if (rst) begin
            m_busy = 0; m_rdy = 0; m_addr = '0; m_wdata = '0;
        end else if (!m_busy) begin
            if (m_rdy && req_valid) begin
                m_busy  = 1; m_rdy = 0; hs_e = ecnt;
                m_legal = (req_addr <= LIMIT);
                m_write = req_write;
                m_err   = !m_legal;
                m_data  = '0;
                if (m_legal) begin
                    m_addr  = req_addr;
                    m_wdata = req_wdata;
                    if (req_write) ref_mem[req_addr[9:0]] = req_wdata;
                    else           m_data = ref_mem[req_addr[9:0]];
                    resp_at = ecnt + L + 1;
                end else begin
                    resp_at = ecnt + 1;
                end
            end else begin
                m_rdy = 1;
            end
        end else if ((ecnt - 1) >= resp_at && resp_ready) begin
            m_busy = 0; m_rdy = 1;
        end
    end

    int mw_cnt = 0, mr_cnt = 0;
    always @(negedge clk) begin
        if (ecnt > 0) begin
            automatic bit strobe = m_busy && m_legal && ecnt >= hs_e && ecnt < hs_e + L;
            automatic bit rv     = m_busy && ecnt >= resp_at;
            chk("req_ready", req_ready, m_rdy);
            chk("resp_valid", resp_valid, rv);
            chk("MemRead", MemRead, strobe && !m_write);
            chk("MemtoReg", MemtoReg, strobe && !m_write);
            chk("MemWrite", MemWrite, strobe && m_write);
            chk("Address", Address, m_addr);
            chk("WriteData", WriteData, m_wdata);
            if (rv) begin
                chk("resp_rdata", resp_rdata, m_data);
                chk("resp_err", resp_err, m_err);
            end
            if (MemWrite) mw_cnt++;
            if (MemRead)  mr_cnt++;
        end
    end

    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && n < 40) begin @(posedge clk); #2; n++; end
        if (!req_ready) tmo("req_handshake");
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!resp_valid && n < 40) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
            @(posedge clk); #2; n++;
        end
        req_valid = 1'b0;
        if (!resp_valid) tmo("resp_wait");
    endtask

    task automatic release_resp(input int hold);
        repeat (hold) begin req_valid = 1'($urandom_range(0, 1)); @(posedge clk); #2; end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #2;
        resp_ready = 1'b0;
    endtask

    initial begin
        int mw0, mr0, n;
        logic [15:0] a;
        for (int i = 0; i < 1024; i++) begin
            dmem[i] = 16'($urandom);
            ref_mem[i] = dmem[i];
        end
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_addr", Address, 16'h0);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("post_rst_req_ready", req_ready, 1'b1);

        // Latency 1, boundary address 1023.
        req_addr1 = 16'd1023; req_valid1 = 1'b1;
        @(posedge clk); #2;
        req_valid1 = 1'b0;
        chk("l1_strobe_on", MemRead1, 1'b1);
        @(posedge clk); #2;
        chk("l1_strobe_off", MemRead1, 1'b0);
        chk("l1_gap_valid", resp_valid1, 1'b0);
        @(posedge clk); #2;
        chk("l1_valid", resp_valid1, 1'b1);
        chk("l1_rdata", resp_rdata1, 16'h3FC3);
        chk("l1_err", resp_err1, 1'b0);
        chk("l1_nowrite", MemWrite1, 1'b0);
        resp_ready1 = 1'b1;
        @(posedge clk); #2;
        resp_ready1 = 1'b0;
        chk("l1_released", resp_valid1, 1'b0);

        // Store then load of address 20.
        mw0 = mw_cnt;
        do_req(1'b1, 16'd20, 16'h02AF);
        wait_valid();
        chk("store_err", resp_err, 1'b0);
        chk("store_rdata", resp_rdata, 16'h0);
        release_resp(0);
        chk("store_mw_cycles", mw_cnt - mw0, 2);
        do_req(1'b0, 16'd20, 16'h0);
        wait_valid();
        chk("load_rdata", resp_rdata, 16'h02AF);
        chk("load_err", resp_err, 1'b0);
        release_resp(0);

        // Out-of-range load.
        mw0 = mw_cnt; mr0 = mr_cnt;
        do_req(1'b0, 16'd1024, 16'h0);
        chk("err_gap_valid", resp_valid, 1'b0);
        @(posedge clk); #2;
        chk("err_valid", resp_valid, 1'b1);
        chk("err_flag", resp_err, 1'b1);
        chk("err_rdata", resp_rdata, 16'h0);
        release_resp(1);
        chk("err_no_read", mr_cnt - mr0, 0);
        chk("err_no_write", mw_cnt - mw0, 0);

        // Backpressure with a competing request held high.
        do_req(1'b0, 16'd20, 16'h0);
        wait_valid();
        req_valid = 1'b1; req_addr = 16'd21; req_write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp_valid, 1'b1);
            chk("bp_rdata", resp_rdata, 16'h02AF);
            chk("bp_req_ready", req_ready, 1'b0);
            @(posedge clk); #2;
        end
        release_resp(0);

        // Reset in the first ACCESS cycle of a store.
        do_req(1'b1, 16'd30, 16'hBEEF);
        chk("rs_mw_on", MemWrite, 1'b1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("rs_mw", MemWrite, 1'b0);
        chk("rs_mr", MemRead, 1'b0);
        chk("rs_addr", Address, 16'h0);
        chk("rs_wdata", WriteData, 16'h0);
        chk("rs_valid", resp_valid, 1'b0);
        chk("rs_rdata", resp_rdata, 16'h0);
        chk("rs_err", resp_err, 1'b0);
        chk("rs_req_ready", req_ready, 1'b0);
        @(posedge clk); #2;
        chk("rs_req_ready_next", req_ready, 1'b1);
        n = 0;
        repeat (4) begin @(posedge clk); #2; if (resp_valid) n++; end
        chk("rs_no_resp", n, 0);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 3))
                0: a = 16'($urandom_range(0, 7));
                1: a = 16'(1016 + $urandom_range(0, 15));
                2: a = 16'($urandom);
                default: a = 16'($urandom_range(16, 24));
            endcase
            do_req(1'($urandom_range(0, 1)), a, 16'($urandom));
            wait_valid();
            release_resp($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
